alarm_clock_ctrl: RTL and testbench

//  Hardware sequencer for the alarm-clock datapath. It keeps time of day as BCD,

---
 rtl/alarm_clock_pkg.sv | 50 +++++
 rtl/bcd_to_7seg.sv | 25 ++
 rtl/alarm_clock_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Alarm clock shared types: edit states, targets, fields,
// segment constants and BCD wrap helpers.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S
  } state_t;

  typedef enum logic {
    TGT_TIME,
    TGT_ALARM
  } target_t;

  typedef enum logic [1:0] {
    FLD_H,
    FLD_M,
    FLD_S
  } field_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX   = 8'h59;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == 8'h00)
      return max;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low segments g..a; codes above 9 blank.
// Ports: bcd (4b digit in), seg (7b segments out).
module bcd_to_7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: BCD time/alarm, SET/UP/DOWN editor,
// alarm output and six registered active-low 7-seg digits.
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ALARM_SECS = 60,
  parameter int BLINK_HZ   = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       btn_set_export,
  input  logic       btn_up_export,
  input  logic       btn_down_export,
  input  logic       swc_sel_export,
  input  logic       swc_alarm_export,
  output logic [7:0] display_h1_export,
  output logic [7:0] display_h0_export,
  output logic [7:0] display_m1_export,
  output logic [7:0] display_m0_export,
  output logic [7:0] display_s1_export,
  output logic [7:0] display_s0_export,
  output logic       alarm_export
);

  localparam int BP = CLK_HZ / BLINK_HZ;
  localparam int TW = $clog2(CLK_HZ + 1);
  localparam int BW = $clog2(BP + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);

  logic [2:0]    set_sr, up_sr, dn_sr;
  logic [1:0]    sel_sr, arm_sr;
  logic          set_p, up_p, dn_p;
  logic          consume, act_set, act_ud;
  logic          edit, edit_time, tick;
  logic          blink_off, trig;
  logic          blank_h, blank_m, blank_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic [AW-1:0] alarm_cnt;
  state_t        state;
  target_t       tgt;
  field_t        fld;
  logic [7:0]    tm_h, tm_m, tm_s;
  logic [7:0]    al_h, al_m, al_s;
  logic [7:0]    nx_h, nx_m, nx_s;
  logic [7:0]    src_h, src_m, src_s;
  logic [7:0]    fld_val, fld_max, fld_new;
  logic [3:0]    dig [6];
  logic [6:0]    seg [6];

  always_comb begin
    // [2] is the previous synced level: 1->0 is a press
    set_p = set_sr[2] & ~set_sr[1];
    up_p  = up_sr[2] & ~up_sr[1];
    dn_p  = dn_sr[2] & ~dn_sr[1];
    // a press that silences the alarm does nothing else
    consume   = alarm_export & (set_p | up_p | dn_p);
    act_set   = set_p & ~consume;
    act_ud    = ~set_p & (up_p ^ dn_p) & ~consume;
    edit      = state != RUN;
    edit_time = edit & (tgt == TGT_TIME);
    tick      = (tick_cnt == TW'(CLK_HZ - 1)) & ~edit_time;
    blink_off = blink_cnt >= BW'(BP / 2);

    nx_s = bcd_inc(tm_s, MIN_MAX);
    nx_m = tm_m;
    nx_h = tm_h;
    if (tm_s == MIN_MAX) begin
      nx_m = bcd_inc(tm_m, MIN_MAX);
      if (tm_m == MIN_MAX)
        nx_h = bcd_inc(tm_h, HOUR_MAX);
    end
    trig = tick & arm_sr[1] & ~alarm_export &
           ({nx_h, nx_m, nx_s} == {al_h, al_m, al_s});

    fld = FLD_S;
    unique case (1'b1)
      state == SET_H: fld = FLD_H;
      state == SET_M: fld = FLD_M;
      default:        fld = FLD_S;
    endcase

    src_h = tm_h;
    src_m = tm_m;
    src_s = tm_s;
    if (edit && tgt == TGT_ALARM) begin
      src_h = al_h;
      src_m = al_m;
      src_s = al_s;
    end

    fld_val = src_s;
    fld_max = MIN_MAX;
    unique case (fld)
      FLD_H: begin
        fld_val = src_h;
        fld_max = HOUR_MAX;
      end
      FLD_M:   fld_val = src_m;
      default: fld_val = src_s;
    endcase
    fld_new = up_p ? bcd_inc(fld_val, fld_max)
                   : bcd_dec(fld_val, fld_max);

    blank_h = edit & blink_off & (fld == FLD_H);
    blank_m = edit & blink_off & (fld == FLD_M);
    blank_s = edit & blink_off & (fld == FLD_S);

    dig[0] = src_h[7:4];
    dig[1] = src_h[3:0];
    dig[2] = src_m[7:4];
    dig[3] = src_m[3:0];
    dig[4] = src_s[7:4];
    dig[5] = src_s[3:0];
  end

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_to_7seg u_seg (
      .bcd (dig[i]),
      .seg (seg[i])
    );
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      set_sr            <= '1;
      up_sr             <= '1;
      dn_sr             <= '1;
      sel_sr            <= '0;
      arm_sr            <= '0;
      tick_cnt          <= '0;
      blink_cnt         <= '0;
      alarm_cnt         <= '0;
      state             <= RUN;
      tgt               <= TGT_TIME;
      {tm_h, tm_m, tm_s} <= '0;
      {al_h, al_m, al_s} <= '0;
      alarm_export      <= 1'b0;
      display_h1_export <= SEG_ZERO;
      display_h0_export <= SEG_ZERO;
      display_m1_export <= SEG_ZERO;
      display_m0_export <= SEG_ZERO;
      display_s1_export <= SEG_ZERO;
      display_s0_export <= SEG_ZERO;
    end else begin
      set_sr <= {set_sr[1:0], btn_set_export};
      up_sr  <= {up_sr[1:0], btn_up_export};
      dn_sr  <= {dn_sr[1:0], btn_down_export};
      sel_sr <= {sel_sr[0], swc_sel_export};
      arm_sr <= {arm_sr[0], swc_alarm_export};

      if (edit_time || tick_cnt == TW'(CLK_HZ - 1))
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);

      if (act_set || blink_cnt == BW'(BP - 1))
        blink_cnt <= '0;
      else
        blink_cnt <= blink_cnt + BW'(1);

      if (tick) begin
        tm_h <= nx_h;
        tm_m <= nx_m;
        tm_s <= nx_s;
      end

      if (act_set) begin
        unique case (state)
          RUN: begin
            state <= SET_H;
            tgt   <= sel_sr[1] ? TGT_ALARM : TGT_TIME;
          end
          SET_H:   state <= SET_M;
          SET_M:   state <= SET_S;
          default: state <= RUN;
        endcase
      end else if (edit && act_ud) begin
        if (tgt == TGT_ALARM) begin
          unique case (fld)
            FLD_H:   al_h <= fld_new;
            FLD_M:   al_m <= fld_new;
            default: al_s <= fld_new;
          endcase
        end else begin
          unique case (fld)
            FLD_H:   tm_h <= fld_new;
            FLD_M:   tm_m <= fld_new;
            default: tm_s <= fld_new;
          endcase
        end
      end

      if (alarm_export) begin
        if (consume || !arm_sr[1] ||
            (tick && alarm_cnt == AW'(1)))
          alarm_export <= 1'b0;
        else if (tick)
          alarm_cnt <= alarm_cnt - AW'(1);
      end else if (trig) begin
        alarm_export <= 1'b1;
        alarm_cnt    <= AW'(ALARM_SECS);
      end

      display_h1_export <= blank_h ? SEG_BLANK
                                   : {1'b1, seg[0]};
      display_h0_export <= blank_h ? SEG_BLANK
                                   : {1'b1, seg[1]};
      display_m1_export <= blank_m ? SEG_BLANK
                                   : {1'b1, seg[2]};
      display_m0_export <= blank_m ? SEG_BLANK
                                   : {1'b1, seg[3]};
      display_s1_export <= blank_s ? SEG_BLANK
                                   : {1'b1, seg[4]};
      display_s0_export <= blank_s ? SEG_BLANK
                                   : {~arm_sr[1], seg[5]};
    end
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl with a 10-cycle second,
// 3-second alarm and 10-cycle blink period.
module tb_alarm_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_set, b_up, b_dn;
  logic        sw_sel, sw_arm;
  logic [7:0]  h1, h0, m1, m0, s1, s0;
  logic        alarm;
  logic [47:0] disp;
  logic [47:0] exp_d;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign disp = {h1, h0, m1, m0, s1, s0};

  alarm_clock_ctrl #(
    .CLK_HZ     (10),
    .ALARM_SECS (3),
    .BLINK_HZ   (1)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .btn_set_export    (b_set),
    .btn_up_export     (b_up),
    .btn_down_export   (b_dn),
    .swc_sel_export    (sw_sel),
    .swc_alarm_export  (sw_arm),
    .display_h1_export (h1),
    .display_h0_export (h0),
    .display_m1_export (m1),
    .display_m0_export (m0),
    .display_s1_export (s1),
    .display_s0_export (s0),
    .alarm_export      (alarm)
  );

  function automatic logic [7:0] sg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] show(
    input int h, input int m, input int s, input logic dp
  );
    logic [7:0] last;
    last    = sg(s % 10);
    last[7] = ~dp;
    return {sg(h / 10), sg(h % 10), sg(m / 10),
            sg(m % 10), sg(s / 10), last};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    b_set = 1'b1;
    b_up  = 1'b1;
    b_dn  = 1'b1;
    rst   = 1'b1;
    cyc(2);
    rst   = 1'b0;
  endtask

  task automatic press(input logic s, input logic u,
                       input logic d);
    b_set = ~s;
    b_up  = ~u;
    b_dn  = ~d;
    cyc(3);
    b_set = 1'b1;
    b_up  = 1'b1;
    b_dn  = 1'b1;
    cyc(3);
  endtask

  // leaves the design in RUN with alarm 00:01:00 armed,
  // 33 cycles after reset release; it fires at cycle 600
  task automatic arm_alarm_1min();
    sw_sel = 1'b1;
    sw_arm = 1'b1;
    do_reset();
    cyc(3);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
  endtask

  task automatic test_reset();
    sw_sel = 1'b0;
    sw_arm = 1'b0;
    do_reset();
    cyc(1);
    n_cmp++;
    if (disp !== {6{8'hC0}}) begin
      n_bad++;
      $display("FAIL reset_disp got %h want %h",
               disp, {6{8'hC0}});
    end
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_alarm got %b want 0", alarm);
    end
  endtask

  task automatic test_count();
    cyc(104);
    exp_d = show(0, 0, 10, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL count_10 got %h want %h", disp, exp_d);
    end
  endtask

  task automatic test_rollover();
    sw_sel = 1'b0;
    sw_arm = 1'b0;
    do_reset();
    cyc(3);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    exp_d = show(23, 59, 59, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL roll_pre got %h want %h", disp, exp_d);
    end
    cyc(10);
    exp_d = show(0, 0, 0, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL roll_post got %h want %h", disp, exp_d);
    end
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL roll_alarm got %b want 0", alarm);
    end
  endtask

  task automatic test_edit_time();
    sw_sel = 1'b0;
    sw_arm = 1'b0;
    do_reset();
    cyc(3);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    cyc(4);
    exp_d = {sg(2), sg(3), 8'hFF, 8'hFF, sg(0), sg(0)};
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL edit_blink got %h want %h", disp, exp_d);
    end
    press(0, 1, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    exp_d = show(23, 2, 0, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL edit_result got %h want %h", disp, exp_d);
    end
    cyc(10);
    exp_d = show(23, 2, 1, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL edit_resume got %h want %h", disp, exp_d);
    end
  endtask

  task automatic test_alarm_expire();
    arm_alarm_1min();
    cyc(566);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL alm_early got %b want 0", alarm);
    end
    cyc(1);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL alm_rise got %b want 1", alarm);
    end
    cyc(29);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL alm_hold got %b want 1", alarm);
    end
    cyc(1);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL alm_expire got %b want 0", alarm);
    end
    exp_d = show(0, 1, 2, 1);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL alm_dp got %h want %h", disp, exp_d);
    end
  endtask

  task automatic test_alarm_clear();
    arm_alarm_1min();
    cyc(567);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_up_pre got %b want 1", alarm);
    end
    b_up = 1'b0;
    cyc(2);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_up_lat got %b want 1", alarm);
    end
    cyc(1);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_up got %b want 0", alarm);
    end
    b_up = 1'b1;
    cyc(3);

    arm_alarm_1min();
    cyc(567);
    sw_arm = 1'b0;
    cyc(2);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_sw_lat got %b want 1", alarm);
    end
    cyc(1);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_sw got %b want 0", alarm);
    end

    arm_alarm_1min();
    cyc(567);
    b_set = 1'b0;
    cyc(3);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_set got %b want 0", alarm);
    end
    b_set = 1'b1;
    cyc(22);
    exp_d = show(0, 1, 2, 1);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL clr_set_run got %h want %h", disp, exp_d);
    end
  endtask

  task automatic test_same_cycle();
    sw_sel = 1'b0;
    sw_arm = 1'b0;
    do_reset();
    cyc(3);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 1);
    exp_d = show(0, 1, 0, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL updn_both got %h want %h", disp, exp_d);
    end
    press(1, 1, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL set_up_min got %h want %h", disp, exp_d);
    end
    cyc(4);
    exp_d = {sg(0), sg(0), sg(0), sg(1), 8'hFF, 8'hFF};
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL set_up_state got %h want %h", disp, exp_d);
    end
    press(1, 0, 0);
    cyc(5);
    exp_d = show(0, 1, 0, 0);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL same_exit got %h want %h", disp, exp_d);
    end
  endtask

  task automatic test_reset_mid_edit();
    arm_alarm_1min();
    cyc(537);
    press(1, 0, 0);
    press(1, 0, 0);
    cyc(18);
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre got %b want 1", alarm);
    end
    rst = 1'b1;
    cyc(1);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_alarm got %b want 0", alarm);
    end
    n_cmp++;
    if (disp !== {6{8'hC0}}) begin
      n_bad++;
      $display("FAIL mid_disp got %h want %h",
               disp, {6{8'hC0}});
    end
    rst = 1'b0;
    cyc(15);
    exp_d = show(0, 0, 1, 1);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL mid_time got %h want %h", disp, exp_d);
    end
    press(1, 0, 0);
    exp_d = show(0, 0, 0, 1);
    n_cmp++;
    if (disp !== exp_d) begin
      n_bad++;
      $display("FAIL mid_alarm_sp got %h want %h", disp, exp_d);
    end
  endtask

  initial begin
    rst    = 1'b1;
    b_set  = 1'b1;
    b_up   = 1'b1;
    b_dn   = 1'b1;
    sw_sel = 1'b0;
    sw_arm = 1'b0;
    test_reset();
    test_count();
    test_rollover();
    test_edit_time();
    test_alarm_expire();
    test_alarm_clear();
    test_same_cycle();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
